id_stage: RTL and testbench

Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of instruction fetch. It contains:
- the IF/ID pipeline register, with stall and flush;
- the 32×32 register file, with write-before-read bypass;
- branch/jump resolution, which returns the redirect controls and target addresses to fetch;
- hazard detection for load-use and branch-operand dependencies;
- the ID/EX output register that feeds execute.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/register_file.sv | 38 +++
 rtl/id_stage.sv | 138 +++++++++++++
 tb/tb_id_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, functs, NOP encoding and instruction field positions.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int IDX_HI = 25;
endpackage

// File: rtl/register_file.sv
// 32-entry register file: one synchronous write port, two combinational read ports.
// A read of the register being written this cycle returns the incoming data.
module register_file #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               wr_en,
  input  logic               byp_en,
  input  logic [NB_REG-1:0]  wr_addr,
  input  logic [NB_DATA-1:0] wr_data,
  input  logic [NB_REG-1:0]  rd_addr_a,
  input  logic [NB_REG-1:0]  rd_addr_b,
  output logic [NB_DATA-1:0] rd_data_a,
  output logic [NB_DATA-1:0] rd_data_b
);
  localparam int NREGS = 2 ** NB_REG;

  logic [NREGS-1:0][NB_DATA-1:0] regs;

  always_ff @(posedge i_clock) begin
    if (i_reset)
      regs <= '0;
    else if (wr_en && wr_addr != '0)
      regs[wr_addr] <= wr_data;
  end

  // r0 is hardwired to zero, so it is never bypassed either
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a != '0)
      rd_data_a = (byp_en && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
    if (rd_addr_b != '0)
      rd_data_b = (byp_en && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
  end
endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID register, register file, branch/jump resolution,
// load-use and branch-operand hazard detection, and the ID/EX register.
module id_stage
  import mips_pkg::*;
#(
  parameter int NB_PC          = 32,
  parameter int NB_INSTRUCTION = 32,
  parameter int NB_DATA        = 32,
  parameter int NB_REG         = 5
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_ID_enable,
  input  logic [NB_INSTRUCTION-1:0] i_ID_instruction,
  input  logic [NB_PC-1:0]          i_ID_pc_plus4,
  input  logic                      i_ID_wb_enable,
  input  logic [NB_REG-1:0]         i_ID_wb_addr,
  input  logic [NB_DATA-1:0]        i_ID_wb_data,
  input  logic                      i_ID_ex_mem_read,
  input  logic                      i_ID_ex_reg_write,
  input  logic [NB_REG-1:0]         i_ID_ex_write_reg,
  output logic                      o_ID_pc_enable,
  output logic                      o_ID_branch,
  output logic                      o_ID_j_jal,
  output logic                      o_ID_jr_jalr,
  output logic [NB_PC-1:0]          o_ID_branch_addr,
  output logic [NB_PC-1:0]          o_ID_jump_address,
  output logic [NB_PC-1:0]          o_ID_r31_data,
  output logic [NB_DATA-1:0]        o_ID_rs_data,
  output logic [NB_DATA-1:0]        o_ID_rt_data,
  output logic [NB_DATA-1:0]        o_ID_imm_ext,
  output logic [NB_REG-1:0]         o_ID_rs,
  output logic [NB_REG-1:0]         o_ID_rt,
  output logic [NB_REG-1:0]         o_ID_rd,
  output logic [4:0]                o_ID_shamt,
  output logic [5:0]                o_ID_opcode,
  output logic [5:0]                o_ID_funct,
  output logic [NB_PC-1:0]          o_ID_pc_plus4
);
  logic [NB_INSTRUCTION-1:0] if_instr;
  logic [NB_PC-1:0]          if_pc4;
  logic [5:0]                opcode, funct;
  logic [NB_REG-1:0]         rs, rt, rd;
  logic [4:0]                shamt;
  logic [15:0]               imm;
  logic [NB_DATA-1:0]        rs_data, rt_data, imm_ext;
  logic is_branch, is_jump, is_jreg;
  logic ex_dst_live, load_use, branch_dep, stall, go, redirect;

  assign opcode = if_instr[OP_HI:OP_LO];
  assign rs     = if_instr[RS_HI:RS_LO];
  assign rt     = if_instr[RT_HI:RT_LO];
  assign rd     = if_instr[RD_HI:RD_LO];
  assign shamt  = if_instr[SH_HI:SH_LO];
  assign funct  = if_instr[FN_HI:FN_LO];
  assign imm    = if_instr[IMM_HI:IMM_LO];

  register_file #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) u_regfile (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .wr_en     (i_ID_wb_enable & i_ID_enable),
    .byp_en    (i_ID_wb_enable),
    .wr_addr   (i_ID_wb_addr),
    .wr_data   (i_ID_wb_data),
    .rd_addr_a (rs),
    .rd_addr_b (rt),
    .rd_data_a (rs_data),
    .rd_data_b (rt_data)
  );

  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
  assign is_jreg   = (opcode == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));

  // Branches compare in ID, so any in-flight EX result they read must wait
  assign ex_dst_live = (i_ID_ex_write_reg != '0);
  assign load_use    = i_ID_ex_mem_read & ex_dst_live &
                       ((i_ID_ex_write_reg == rs) | (i_ID_ex_write_reg == rt));
  assign branch_dep  = i_ID_ex_reg_write & ex_dst_live &
                       ((is_branch & ((i_ID_ex_write_reg == rs) | (i_ID_ex_write_reg == rt))) |
                        (is_jreg & (i_ID_ex_write_reg == rs)));
  assign stall = load_use | branch_dep;
  assign go    = i_ID_enable & ~stall;

  assign o_ID_pc_enable = go;
  assign o_ID_branch    = go & (((opcode == OP_BEQ) & (rs_data == rt_data)) |
                                ((opcode == OP_BNE) & (rs_data != rt_data)));
  assign o_ID_j_jal     = go & is_jump;
  assign o_ID_jr_jalr   = go & is_jreg;
  assign redirect       = o_ID_branch | o_ID_j_jal | o_ID_jr_jalr;

  assign imm_ext           = NB_DATA'($signed(imm));
  assign o_ID_branch_addr  = if_pc4 + {imm_ext[NB_PC-3:0], 2'b00};
  assign o_ID_jump_address = {if_pc4[NB_PC-1:NB_PC-4], if_instr[IDX_HI:0], 2'b00};
  assign o_ID_r31_data     = NB_PC'(rs_data);

  // Taken redirect squashes the instruction fetched behind it (no delay slot)
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      if_instr <= NOP;
      if_pc4   <= '0;
    end else if (go) begin
      if (redirect) begin
        if_instr <= NOP;
        if_pc4   <= '0;
      end else begin
        if_instr <= i_ID_instruction;
        if_pc4   <= i_ID_pc_plus4;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || (i_ID_enable && stall)) begin
      o_ID_rs_data  <= '0;
      o_ID_rt_data  <= '0;
      o_ID_imm_ext  <= '0;
      o_ID_rs       <= '0;
      o_ID_rt       <= '0;
      o_ID_rd       <= '0;
      o_ID_shamt    <= '0;
      o_ID_opcode   <= '0;
      o_ID_funct    <= '0;
      o_ID_pc_plus4 <= '0;
    end else if (i_ID_enable) begin
      o_ID_rs_data  <= rs_data;
      o_ID_rt_data  <= rt_data;
      o_ID_imm_ext  <= imm_ext;
      o_ID_rs       <= rs;
      o_ID_rt       <= rt;
      o_ID_rd       <= rd;
      o_ID_shamt    <= shamt;
      o_ID_opcode   <= opcode;
      o_ID_funct    <= funct;
      o_ID_pc_plus4 <= if_pc4;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed scenarios plus random traffic, each cycle's
// expected outputs come from a behavioural model and are checked by a monitor.
module tb_id_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, wb_en, ex_mr, ex_rw;
  logic [31:0] instr, pc4, wd;
  logic [4:0]  wa, ex_wr;

  logic        pc_en, br, jj, jr;
  logic [31:0] baddr, jaddr, r31, rs_data, rt_data, imm_ext, ex_pc4;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  opcode, funct;

  id_stage dut (
    .i_clock(clk), .i_reset(rst), .i_ID_enable(en),
    .i_ID_instruction(instr), .i_ID_pc_plus4(pc4),
    .i_ID_wb_enable(wb_en), .i_ID_wb_addr(wa), .i_ID_wb_data(wd),
    .i_ID_ex_mem_read(ex_mr), .i_ID_ex_reg_write(ex_rw), .i_ID_ex_write_reg(ex_wr),
    .o_ID_pc_enable(pc_en), .o_ID_branch(br), .o_ID_j_jal(jj), .o_ID_jr_jalr(jr),
    .o_ID_branch_addr(baddr), .o_ID_jump_address(jaddr), .o_ID_r31_data(r31),
    .o_ID_rs_data(rs_data), .o_ID_rt_data(rt_data), .o_ID_imm_ext(imm_ext),
    .o_ID_rs(rs), .o_ID_rt(rt), .o_ID_rd(rd), .o_ID_shamt(shamt),
    .o_ID_opcode(opcode), .o_ID_funct(funct), .o_ID_pc_plus4(ex_pc4)
  );

  typedef struct {
    logic rst, en, wb_en, ex_mr, ex_rw;
    logic [31:0] instr, pc4, wd;
    logic [4:0] wa, ex_wr;
  } stim_t;

  typedef struct packed {
    logic [31:0] rs_data, rt_data, imm, pc4;
    logic [4:0] rs, rt, rd, shamt;
    logic [5:0] op, funct;
  } idex_t;

  typedef struct {
    logic pc_en, br, jj, jr;
    logic [31:0] baddr, jaddr, r31;
    idex_t ex;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_fail = 0;

  // model state (current) and state after the coming edge
  logic [31:0] m_regs[32], n_regs[32];
  logic [31:0] m_if_instr, m_if_pc4, n_if_instr, n_if_pc4;
  idex_t m_ex, n_ex;
  bit have_next = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdreg(input logic [4:0] i, input stim_t s);
    if (i == 0) return 32'h0;
    if (s.wb_en && s.wa == i) return s.wd;
    return m_regs[i];
  endfunction

  task automatic eval(input stim_t s, output exp_t e);
    logic [5:0] op, fn;
    logic [4:0] a, b;
    logic [31:0] av, bv, sx;
    logic beq, bne, jmp, jreg, stall, go;
    op = m_if_instr[31:26]; fn = m_if_instr[5:0];
    a = m_if_instr[25:21];  b = m_if_instr[20:16];
    av = rdreg(a, s);       bv = rdreg(b, s);
    sx = {{16{m_if_instr[15]}}, m_if_instr[15:0]};
    beq = (op == 6'd4); bne = (op == 6'd5);
    jmp = (op == 6'd2) || (op == 6'd3);
    jreg = (op == 6'd0) && (fn == 6'd8 || fn == 6'd9);
    stall = (s.ex_mr && s.ex_wr != 0 && (s.ex_wr == a || s.ex_wr == b)) ||
            (s.ex_rw && s.ex_wr != 0 &&
             (((beq || bne) && (s.ex_wr == a || s.ex_wr == b)) || (jreg && s.ex_wr == a)));
    go = s.en && !stall;
    e.pc_en = go;
    e.br    = go && ((beq && av == bv) || (bne && av != bv));
    e.jj    = go && jmp;
    e.jr    = go && jreg;
    e.baddr = m_if_pc4 + sx * 4;
    e.jaddr = (m_if_pc4 & 32'hF000_0000) | ((m_if_instr & 32'h03FF_FFFF) * 4);
    e.r31   = av;
    e.ex    = m_ex;

    n_regs = m_regs; n_if_instr = m_if_instr; n_if_pc4 = m_if_pc4; n_ex = m_ex;
    if (s.rst) begin
      foreach (n_regs[i]) n_regs[i] = 0;
      n_if_instr = 0; n_if_pc4 = 0; n_ex = '0;
    end else begin
      if (s.en && s.wb_en && s.wa != 0) n_regs[s.wa] = s.wd;
      if (s.en) begin
        if (stall) n_ex = '0;
        else n_ex = '{rs_data: av, rt_data: bv, imm: sx, pc4: m_if_pc4,
                      rs: a, rt: b, rd: m_if_instr[15:11], shamt: m_if_instr[10:6],
                      op: op, funct: fn};
      end
      if (go) begin
        if (e.br || e.jj || e.jr) begin n_if_instr = 0; n_if_pc4 = 0; end
        else begin n_if_instr = s.instr; n_if_pc4 = s.pc4; end
      end
    end
  endtask

  // One cycle: commit the previous edge into the model, drive, predict, leave comb outputs settled
  task automatic cycle(input stim_t s);
    exp_t e;
    @(posedge clk);
    if (have_next) begin
      m_regs = n_regs; m_if_instr = n_if_instr; m_if_pc4 = n_if_pc4; m_ex = n_ex;
    end
    #1;
    rst = s.rst; en = s.en; instr = s.instr; pc4 = s.pc4;
    wb_en = s.wb_en; wa = s.wa; wd = s.wd; ex_mr = s.ex_mr; ex_rw = s.ex_rw; ex_wr = s.ex_wr;
    eval(s, e);
    q.push_back(e);
    have_next = 1;
    #2;
  endtask

  exp_t  mon_e;
  idex_t mon_act;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_act = '{rs_data: rs_data, rt_data: rt_data, imm: imm_ext, pc4: ex_pc4,
                  rs: rs, rt: rt, rd: rd, shamt: shamt, op: opcode, funct: funct};
      chk("pc_enable", 32'(pc_en), 32'(mon_e.pc_en));
      chk("branch",    32'(br),    32'(mon_e.br));
      chk("j_jal",     32'(jj),    32'(mon_e.jj));
      chk("jr_jalr",   32'(jr),    32'(mon_e.jr));
      chk("branch_addr", baddr, mon_e.baddr);
      chk("jump_address", jaddr, mon_e.jaddr);
      chk("r31_data", r31, mon_e.r31);
      chk("idex_rs_data", mon_act.rs_data, mon_e.ex.rs_data);
      chk("idex_rt_data", mon_act.rt_data, mon_e.ex.rt_data);
      chk("idex_imm", mon_act.imm, mon_e.ex.imm);
      chk("idex_pc4", mon_act.pc4, mon_e.ex.pc4);
      chk("idex_fields", {6'h0, mon_act.rs, mon_act.rt, mon_act.rd, mon_act.shamt, mon_act.op, mon_act.funct},
                         {6'h0, mon_e.ex.rs, mon_e.ex.rt, mon_e.ex.rd, mon_e.ex.shamt, mon_e.ex.op, mon_e.ex.funct});
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, en: 1'b1, wb_en: 1'b0, ex_mr: 1'b0, ex_rw: 1'b0,
          instr: 32'h0, pc4: 32'h0, wd: 32'h0, wa: 5'd0, ex_wr: 5'd0};
    return s;
  endfunction

  function automatic logic [4:0] rr();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd2;
      3: return 5'd3;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    case ($urandom_range(0, 8))
      0: return {6'h00, rr(), rr(), rr(), 5'($urandom), 6'h20};
      1: return {6'h23, rr(), rr(), 16'($urandom)};
      2: return {6'h04, rr(), rr(), 16'($urandom)};
      3: return {6'h05, rr(), rr(), 16'($urandom)};
      4: return {6'h02, 26'($urandom)};
      5: return {6'h03, 26'($urandom)};
      6: return {6'h00, rr(), 10'h0, 5'h0, 6'h08};
      7: return {6'h00, rr(), 5'h0, 5'd31, 5'h0, 6'h09};
      default: return 32'($urandom);
    endcase
  endfunction

  localparam logic [31:0] ADD_FILL = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};

  initial begin
    stim_t s;
    foreach (m_regs[i]) m_regs[i] = 0;
    m_if_instr = 0; m_if_pc4 = 0; m_ex = '0;
    rst = 1; en = 1; instr = 0; pc4 = 0; wb_en = 0; wa = 0; wd = 0;
    ex_mr = 0; ex_rw = 0; ex_wr = 0;

    // reset held while writeback tries to write r5
    s = idle(); s.rst = 1; s.wb_en = 1; s.wa = 5; s.wd = 32'hDEAD_BEEF;
    cycle(s); cycle(s);
    s = idle(); s.instr = {6'h00, 5'd5, 5'd5, 5'd6, 5'd0, 6'h20};
    cycle(s);
    chk("post_reset_pc_enable", 32'(pc_en), 32'd1);
    cycle(idle());
    chk("reset_r5_zero", r31, 32'h0);

    // r5 = 0xAA, BEQ r5,r5,-1 at pc+4 0x40
    s = idle(); s.wb_en = 1; s.wa = 5; s.wd = 32'h0000_00AA;
    s.instr = {6'h04, 5'd5, 5'd5, 16'hFFFF}; s.pc4 = 32'h40;
    cycle(s);
    s = idle(); s.instr = ADD_FILL; s.pc4 = 32'h44;
    cycle(s);
    chk("beq_taken", 32'(br), 32'd1);
    chk("beq_target", baddr, 32'h0000_003C);

    // JAL index 0x10 at pc+4 0x9000_0004
    s = idle(); s.instr = {6'h03, 26'h10}; s.pc4 = 32'h9000_0004;
    cycle(s);
    chk("flushed_no_branch", 32'(br), 32'd0);
    s = idle(); s.instr = ADD_FILL;
    cycle(s);
    chk("jal_taken", 32'(jj), 32'd1);
    chk("jal_target", jaddr, 32'h9000_0040);

    // load-use: EX loads r8, ID holds ADD r9,r8,r1
    s = idle(); s.instr = {6'h00, 5'd8, 5'd1, 5'd9, 5'd0, 6'h20}; s.pc4 = 32'h100;
    cycle(s);
    s = idle(); s.ex_mr = 1; s.ex_rw = 1; s.ex_wr = 8;
    cycle(s);
    chk("load_use_stall", 32'(pc_en), 32'd0);
    s = idle(); s.wb_en = 1; s.wa = 8; s.wd = 32'h0000_1234;
    s.instr = {6'h00, 5'd31, 10'h0, 5'h0, 6'h08}; s.pc4 = 32'h104;
    cycle(s);
    chk("load_use_release", 32'(pc_en), 32'd1);

    // JR r31 while EX writes r31
    s = idle(); s.ex_rw = 1; s.ex_wr = 31;
    cycle(s);
    chk("jr_stall", 32'(pc_en), 32'd0);
    chk("jr_stalled_no_redirect", 32'(jr), 32'd0);
    chk("add_issued_r8", rs_data, 32'h0000_1234);
    s = idle(); s.wb_en = 1; s.wa = 31; s.wd = 32'hCAFE_0000;
    cycle(s);
    chk("jr_taken", 32'(jr), 32'd1);
    chk("jr_target", r31, 32'hCAFE_0000);

    // r0 ignores writes; same-cycle write/read of r3 is bypassed
    s = idle(); s.wb_en = 1; s.wa = 0; s.wd = 32'hFFFF_FFFF;
    s.instr = {6'h00, 5'd0, 5'd3, 5'd4, 5'd0, 6'h20}; s.pc4 = 32'h200;
    cycle(s);
    s = idle(); s.wb_en = 1; s.wa = 3; s.wd = 32'h0000_0033;
    cycle(s);
    chk("r0_reads_zero", r31, 32'h0);
    cycle(idle());
    chk("idex_r0_zero", rs_data, 32'h0);
    chk("idex_r3_bypass", rt_data, 32'h0000_0033);

    // randomized traffic with a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      s.rst   = ($urandom_range(0, 63) == 0);
      s.en    = ($urandom_range(0, 7) != 0);
      s.instr = rnd_instr();
      s.pc4   = $urandom;
      s.wb_en = 1'($urandom);
      s.wa    = rr();
      s.wd    = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 2)) : $urandom;
      s.ex_mr = ($urandom_range(0, 3) == 0);
      s.ex_rw = 1'($urandom);
      s.ex_wr = rr();
      cycle(s);
    end

    @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
